// File: rtl/haze_window_gen3x3_if.sv
// Pixel stream in / 3x3 RGB window out bus for haze_window_gen3x3.
// slave = the window generator, master = the video source / estimator side.
interface haze_window_gen3x3_if #(
  parameter int PIX_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic               in_sof;
  logic [PIX_W-1:0]   in_r;
  logic [PIX_W-1:0]   in_g;
  logic [PIX_W-1:0]   in_b;
  logic [9*PIX_W-1:0] win_r;
  logic [9*PIX_W-1:0] win_g;
  logic [9*PIX_W-1:0] win_b;
  logic               win_valid;
  logic               win_sof;
  logic               win_eof;

  modport slave (
    input  in_valid, in_sof, in_r, in_g, in_b,
    output in_ready, win_r, win_g, win_b, win_valid, win_sof, win_eof
  );

  modport master (
    output in_valid, in_sof, in_r, in_g, in_b,
    input  in_ready, win_r, win_g, win_b, win_valid, win_sof, win_eof
  );
endinterface

// File: rtl/haze_window_gen3x3.sv
// Raster RGB 3x3 neighbourhood generator feeding the dark-channel min/max trees.
// HAZE_WIN_ZERO_PAD_EN: out-of-image taps read 0 instead of the nearest edge pixel.
module haze_window_gen3x3 #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
) (
  input  logic clock,
  input  logic reset_n,
  haze_window_gen3x3_if.slave bus
);
  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H + 2);
  localparam int PW3 = 3 * PIX_W;
  localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_PAST  = YW'(IMG_H);
  localparam logic [YW-1:0] Y_FLUSH = YW'(IMG_H + 1);
`ifdef HAZE_WIN_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t             state, state_nxt;
  logic               rdy, rdy_nxt;
  logic               accept, restart, step, emit;
  logic               left_out, right_out, top_out, bot_out, sof_hit, eof_hit;
  logic [XW-1:0]      x_cnt, cur_x, x_nxt;
  logic [YW-1:0]      y_cnt, cur_y, y_nxt;
  logic [PW3-1:0]     lb1 [IMG_W];
  logic [PW3-1:0]     lb2 [IMG_W];
  logic [PW3-1:0]     col_new [3];
  logic [PW3-1:0]     col_p1 [3];
  logic [PW3-1:0]     col_p2 [3];
  logic [PW3-1:0]     hpass [3][3];
  logic [PW3-1:0]     tap [3][3];
  logic [9*PIX_W-1:0] win_r_nxt, win_g_nxt, win_b_nxt;

  function automatic logic [PW3-1:0] edge_tap(input logic outside,
                                              input logic [PW3-1:0] raw,
                                              input logic [PW3-1:0] inner);
    if (!outside) return raw;
    return ZERO_PAD ? '0 : inner;
  endfunction

  // A step is one accepted pixel or one self-generated flush slot; it feeds input index (cur_x, cur_y).
  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    accept    = bus.in_valid & rdy;
    restart   = accept & bus.in_sof;
    case (state)
      IDLE: if (restart) begin
        step      = 1'b1;
        state_nxt = RUN;
      end
      RUN: if (accept) begin
        step = 1'b1;
        if (!restart && x_cnt == X_LAST && y_cnt == Y_LAST) state_nxt = FLUSH;
      end
      FLUSH: begin
        step = 1'b1;
        if (x_cnt == '0 && y_cnt == Y_FLUSH) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    rdy_nxt = (state_nxt != FLUSH);
  end

  // The window centre trails the input index by IMG_W+1; at cur_x==0 it sits on the previous row's last column.
  always_comb begin
    cur_x     = restart ? '0 : x_cnt;
    cur_y     = restart ? '0 : y_cnt;
    x_nxt     = (cur_x == X_LAST) ? '0 : cur_x + XW'(1);
    y_nxt     = (cur_x == X_LAST) ? cur_y + YW'(1) : cur_y;
    emit      = (cur_y >= YW'(2)) || (cur_y == YW'(1) && cur_x != '0);
    left_out  = (cur_x == XW'(1));
    right_out = (cur_x == '0);
    top_out   = (cur_x == '0) ? (cur_y == YW'(2)) : (cur_y == YW'(1));
    bot_out   = (cur_x == '0) ? (cur_y == Y_FLUSH) : (cur_y == Y_PAST);
    sof_hit   = (cur_x == XW'(1)) && (cur_y == YW'(1));
    eof_hit   = (cur_x == '0) && (cur_y == Y_FLUSH);
  end

  // Every column holds rows centre-1..centre+1; columns are edge-fixed first, then rows.
  always_comb begin
    col_new[0] = lb2[cur_x];
    col_new[1] = lb1[cur_x];
    col_new[2] = {bus.in_r, bus.in_g, bus.in_b};
    for (int r = 0; r < 3; r++) begin
      hpass[r][0] = edge_tap(left_out, col_p2[r], col_p1[r]);
      hpass[r][1] = col_p1[r];
      hpass[r][2] = edge_tap(right_out, col_new[r], col_p1[r]);
    end
    for (int c = 0; c < 3; c++) begin
      tap[0][c] = edge_tap(top_out, hpass[0][c], hpass[1][c]);
      tap[1][c] = hpass[1][c];
      tap[2][c] = edge_tap(bot_out, hpass[2][c], hpass[1][c]);
    end
    win_r_nxt = '0;
    win_g_nxt = '0;
    win_b_nxt = '0;
    for (int k = 0; k < 9; k++) begin
      win_r_nxt[k*PIX_W +: PIX_W] = tap[k/3][k%3][3*PIX_W-1 -: PIX_W];
      win_g_nxt[k*PIX_W +: PIX_W] = tap[k/3][k%3][2*PIX_W-1 -: PIX_W];
      win_b_nxt[k*PIX_W +: PIX_W] = tap[k/3][k%3][PIX_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      rdy   <= 1'b0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else begin
      state <= state_nxt;
      rdy   <= rdy_nxt;
      if (step) begin
        x_cnt <= x_nxt;
        y_cnt <= y_nxt;
      end
    end
  end

  assign bus.in_ready = rdy;

  always_ff @(posedge clock) begin
    if (step) begin
      lb1[cur_x] <= col_new[2];
      lb2[cur_x] <= col_new[1];
      for (int r = 0; r < 3; r++) begin
        col_p1[r] <= col_new[r];
        col_p2[r] <= col_p1[r];
      end
    end
  end

  // Output register stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.win_valid <= 1'b0;
      bus.win_sof   <= 1'b0;
      bus.win_eof   <= 1'b0;
      bus.win_r     <= '0;
      bus.win_g     <= '0;
      bus.win_b     <= '0;
    end else begin
      bus.win_valid <= step & emit;
      bus.win_sof   <= step & emit & sof_hit;
      bus.win_eof   <= step & emit & eof_hit;
      if (step & emit) begin
        bus.win_r <= win_r_nxt;
        bus.win_g <= win_g_nxt;
        bus.win_b <= win_b_nxt;
      end
    end
  end
endmodule

// File: tb/tb_haze_window_gen3x3.sv
// Bench for haze_window_gen3x3 on a 4x3 image with a neighbourhood model of each window.
module tb_haze_window_gen3x3;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PW = 8;
  localparam int N  = W * H;
`ifdef HAZE_WIN_ZERO_PAD_EN
  localparam bit ZPAD = 1'b1;
`else
  localparam bit ZPAD = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  haze_window_gen3x3_if #(.PIX_W(PW)) bus ();
  haze_window_gen3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    logic [9*PW-1:0] r, g, b;
    logic            sof, eof;
    int              cyc;
  } win_rec_t;

  win_rec_t        wq[$];
  win_rec_t        mon_rec;
  int              acc_q[$];
  int              ready_low   = 0;
  int              cyc         = 0;
  int              vectors     = 0;
  int              miscompares = 0;
  logic [PW-1:0]   img   [3][N];
  logic [PW-1:0]   img_a [3][N];
  logic [PW-1:0]   img_b [3][N];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.win_valid) begin
        mon_rec.r   = bus.win_r;
        mon_rec.g   = bus.win_g;
        mon_rec.b   = bus.win_b;
        mon_rec.sof = bus.win_sof;
        mon_rec.eof = bus.win_eof;
        mon_rec.cyc = cyc;
        wq.push_back(mon_rec);
      end
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
      if (!bus.in_ready) ready_low++;
    end
  end

  // Expected window around (cx,cy): nearest-pixel clamp, or zero outside the image.
  function automatic logic [9*PW-1:0] model_win(input int cx, input int cy, input int ch);
    logic [9*PW-1:0] w;
    int xx, yy;
    bit pad;
    w = '0;
    for (int k = 0; k < 9; k++) begin
      yy  = cy + k / 3 - 1;
      xx  = cx + k % 3 - 1;
      pad = (yy < 0) || (yy >= H) || (xx < 0) || (xx >= W);
      if (yy < 0) yy = 0;
      if (yy >= H) yy = H - 1;
      if (xx < 0) xx = 0;
      if (xx >= W) xx = W - 1;
      if (!(pad && ZPAD)) w[k*PW +: PW] = img[ch][yy*W + xx];
    end
    return w;
  endfunction

  task automatic fill_pattern();
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < N; i++) img[c][i] = PW'(16 * (i / W) + i % W);
  endtask

  task automatic fill_random();
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < N; i++) img[c][i] = PW'($urandom);
  endtask

  task automatic clear_mon();
    wq.delete();
    acc_q.delete();
    ready_low = 0;
  endtask

  task automatic drive_pixel(input int idx, input bit sof, input bit gap);
    bit got;
    int guard;
    got   = 1'b0;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_r     = img[0][idx];
    bus.in_g     = img[1][idx];
    bus.in_b     = img[2][idx];
    while (!got && guard < 20) begin
      @(negedge clock);
      got = bus.in_ready;
      @(posedge clock);
      #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL handshake pix%0d: in_ready never high, wanted 1", idx);
    end
    if (gap) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_r     = '0;
    bus.in_g     = '0;
    bus.in_b     = '0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", bus.in_ready); end
    vectors++;
    if ({bus.win_valid, bus.win_sof, bus.win_eof} !== 3'b000) begin
      miscompares++; $display("FAIL reset_flags got %b want 000", {bus.win_valid, bus.win_sof, bus.win_eof});
    end
    vectors++;
    if ((bus.win_r | bus.win_g | bus.win_b) !== '0) begin
      miscompares++; $display("FAIL reset_win got %h want 0", bus.win_r | bus.win_g | bus.win_b);
    end
    @(negedge clock) reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL idle_ready got %b want 1", bus.in_ready); end
  endtask

  // One full frame; checks contents, flags, per-window latency and flush length.
  task automatic test_frame(input bit random_pix, input bit gap);
    logic [9*PW-1:0] c_11, c_00;
    int want;
    c_11 = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
    c_00 = ZPAD ? {8'h11, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
                : {8'h11, 8'h10, 8'h10, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
    if (random_pix) fill_random(); else fill_pattern();
    clear_mon();
    for (int i = 0; i < N; i++) drive_pixel(i, i == 0, gap);
    repeat (12) @(posedge clock);
    #1;
    vectors++;
    if (wq.size() !== N) begin miscompares++; $display("FAIL frame_count got %0d want %0d", wq.size(), N); end
    vectors++;
    if (ready_low !== W + 1) begin miscompares++; $display("FAIL flush_len got %0d want %0d", ready_low, W + 1); end
    for (int k = 0; k < wq.size() && k < N; k++) begin
      vectors++;
      if (wq[k].r !== model_win(k % W, k / W, 0) || wq[k].g !== model_win(k % W, k / W, 1) ||
          wq[k].b !== model_win(k % W, k / W, 2)) begin
        miscompares++;
        $display("FAIL frame_win%0d r/g/b got %h/%h/%h want %h/%h/%h", k, wq[k].r, wq[k].g, wq[k].b,
                 model_win(k % W, k / W, 0), model_win(k % W, k / W, 1), model_win(k % W, k / W, 2));
      end
      vectors++;
      if (wq[k].sof !== (k == 0) || wq[k].eof !== (k == N - 1)) begin
        miscompares++;
        $display("FAIL frame_flags%0d sof/eof got %b%b want %b%b", k, wq[k].sof, wq[k].eof, k == 0, k == N - 1);
      end
      if (k + W + 1 < N) want = (k + W + 1 < acc_q.size()) ? acc_q[k + W + 1] + 1 : -1;
      else want = wq[k - 1].cyc + 1;
      vectors++;
      if (wq[k].cyc !== want) begin
        miscompares++; $display("FAIL frame_timing%0d cycle got %0d want %0d", k, wq[k].cyc, want);
      end
    end
    if (!random_pix && wq.size() > 5) begin
      vectors++;
      if (wq[5].r !== c_11) begin miscompares++; $display("FAIL centre_1_1 got %h want %h", wq[5].r, c_11); end
      vectors++;
      if (wq[0].r !== c_00) begin miscompares++; $display("FAIL corner_0_0 got %h want %h", wq[0].r, c_00); end
    end
  endtask

  task automatic test_idle_restart();
    int eofs;
    clear_mon();
    fill_random();
    for (int i = 0; i < 3; i++) drive_pixel(i, 1'b0, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    vectors++;
    if (wq.size() !== 0) begin miscompares++; $display("FAIL idle_drop windows got %0d want 0", wq.size()); end
    fill_random();
    img_a = img;
    for (int i = 0; i < 7; i++) drive_pixel(i, i == 0, 1'b0);
    fill_random();
    img_b = img;
    for (int i = 0; i < N; i++) drive_pixel(i, i == 0, 1'b0);
    repeat (12) @(posedge clock);
    #1;
    vectors++;
    if (wq.size() !== N + 2) begin miscompares++; $display("FAIL restart_count got %0d want %0d", wq.size(), N + 2); end
    eofs = 0;
    foreach (wq[j]) eofs += int'(wq[j].eof);
    vectors++;
    if (eofs !== 1) begin miscompares++; $display("FAIL restart_eofs got %0d want 1", eofs); end
    img = img_a;
    for (int k = 0; k < 2 && k < wq.size(); k++) begin
      vectors++;
      if (wq[k].r !== model_win(k, 0, 0) || wq[k].g !== model_win(k, 0, 1) || wq[k].b !== model_win(k, 0, 2) ||
          wq[k].sof !== (k == 0) || wq[k].eof !== 1'b0) begin
        miscompares++; $display("FAIL aborted_win%0d r got %h want %h", k, wq[k].r, model_win(k, 0, 0));
      end
    end
    img = img_b;
    for (int k = 0; k < N && k + 2 < wq.size(); k++) begin
      vectors++;
      if (wq[k+2].r !== model_win(k % W, k / W, 0) || wq[k+2].g !== model_win(k % W, k / W, 1) ||
          wq[k+2].b !== model_win(k % W, k / W, 2)) begin
        miscompares++; $display("FAIL restart_win%0d r got %h want %h", k, wq[k+2].r, model_win(k % W, k / W, 0));
      end
      vectors++;
      if (wq[k+2].sof !== (k == 0) || wq[k+2].eof !== (k == N - 1)) begin
        miscompares++;
        $display("FAIL restart_flags%0d sof/eof got %b%b want %b%b", k, wq[k+2].sof, wq[k+2].eof, k == 0, k == N - 1);
      end
    end
  endtask

  task automatic test_reset_flush();
    fill_random();
    clear_mon();
    for (int i = 0; i < N; i++) drive_pixel(i, i == 0, 1'b0);
    @(posedge clock);
    #1;
    vectors++;
    if ({bus.win_valid, bus.in_ready} !== 2'b10) begin
      miscompares++; $display("FAIL flush_active valid/ready got %b want 10", {bus.win_valid, bus.in_ready});
    end
    #3 reset_n = 1'b0;
    #1;
    vectors++;
    if ({bus.win_valid, bus.win_sof, bus.win_eof, bus.in_ready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_reset ctl got %b want 0000", {bus.win_valid, bus.win_sof, bus.win_eof, bus.in_ready});
    end
    vectors++;
    if ((bus.win_r | bus.win_g | bus.win_b) !== '0) begin
      miscompares++; $display("FAIL async_reset_win got %h want 0", bus.win_r | bus.win_g | bus.win_b);
    end
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock);
    #1;
    vectors++;
    if ({bus.in_ready, bus.win_valid} !== 2'b10) begin
      miscompares++; $display("FAIL post_reset ready/valid got %b want 10", {bus.in_ready, bus.win_valid});
    end
  endtask

  initial begin
    test_reset();
    test_frame(1'b0, 1'b0);
    test_frame(1'b1, 1'b1);
    test_idle_restart();
    test_reset_flush();
    test_frame(1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, wanted completion");
    $fatal(1);
  end
endmodule

// File: doc/haze_window_gen3x3.md
Name: haze_window_gen3x3

Overview:
- Raster-scan RGB pixel source for the dark-channel transmission stage.
- Buffers two image lines per colour channel.
- Emits one full 3x3 R/G/B neighbourhood per pixel position, plus a valid/enable strobe, so the downstream 9-input min/max trees receive r1..r9, g1..g9, b1..b9 directly.
- Sits between the video input stream and the transmission estimator. It is the producer end of the estimator's window interface.

Parameters:
- IMG_W, 640, active pixels per line (>=3)
- IMG_H, 480, lines per frame (>=3)
- PIX_W, 8, bits per colour component

Ports:
- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input pixel present
- in_ready  out  1  block accepts pixel this cycle
- in_sof  in  1  first pixel of frame, qualified by in_valid
- in_r, in_g, in_b  in  PIX_W each  input pixel components
- win_r, win_g, win_b  out  9*PIX_W each  window; element k (1..9) at bits [k*PIX_W-1:(k-1)*PIX_W]; row-major from top-left; element 5 is centre
- win_valid  out  1  window valid; drives downstream Enable
- win_sof  out  1  window centred on (0,0)
- win_eof  out  1  window centred on (IMG_W-1, IMG_H-1)

Behaviour:
- Reset (asynchronous, on reset_n low) clears all outputs, counters and state to 0, and sets state to IDLE. in_ready=0 during reset. Line-buffer contents are don't-care.
- States and transitions:
  - IDLE: in_ready=1. Pixels without in_sof are dropped. A pixel with in_valid&in_sof is accepted as (0,0) and the block moves to RUN.
  - RUN: in_ready=1. Each accepted pixel advances x, wrapping to 0 at IMG_W-1 and incrementing y. in_sof during RUN restarts the frame: the pixel becomes (0,0), pending windows are discarded, and no win_eof is emitted for the aborted frame. After pixel (IMG_W-1, IMG_H-1) is accepted, go to FLUSH.
  - FLUSH: in_ready=0. The block self-generates IMG_W+1 virtual cycles, one per clock, to emit the remaining windows. It then returns to IDLE, with in_ready=1 on the next cycle.
- Window timing:
  - The window centred on (x,y) is registered on the clock after input pixel index (y+1)*IMG_W+x+1 is accepted.
  - Input indices beyond the last pixel are supplied by FLUSH cycles.
  - Fixed latency is IMG_W+1 accepted pixels plus 1 clock.
  - Exactly IMG_W*IMG_H windows per frame, in raster order, at most one per clock.
  - win_valid gaps mirror in_valid gaps.
  - No back-pressure from downstream.
- Borders: taps outside the image take the nearest in-image pixel (row and column clamp independently). Corner (0,0) window elements 1,2,4 equal the pixel at (0,0).
- Storage: two line buffers of IMG_W x 3*PIX_W each, single read plus single write per cycle. Plus a 3x3 shift register per channel.
- Flags: win_sof and win_eof are asserted only together with win_valid. Both assert for a single pixel, and only when IMG_W*IMG_H=1, which parameter limits exclude.
- No arithmetic on pixel values; data passes through bit-exact.

Optional Feature:
- Macro: HAZE_WIN_ZERO_PAD_EN.
- Defined: out-of-image taps are driven to 0 instead of clamped. The centre element is always a real pixel.
- Undefined: clamp/replicate as above.
- Timing, counts and flags are identical in both builds.

Test Plan:
All scenarios use IMG_W=4, IMG_H=3 and pixel value = 16*y+x, identical on R/G/B.
- Reset then continuous 12-pixel frame with in_sof on the first pixel -> 12 win_valid pulses; first window appears 1 clock after the 6th accepted pixel; win_sof on the first window, win_eof on the 12th; in_ready low for exactly 5 cycles.
- Window centred on (1,1) -> win_r elements 1..9 = 00,01,02,10,11,12,20,21,22 (hex).
- Window centred on (0,0), clamp build -> 00,00,01,00,00,01,10,10,11. Zero-pad build -> 00,00,00,00,00,01,00,10,11.
- in_valid toggled every other cycle -> identical window sequence, with win_valid gaps matching; no duplicates or drops.
- Pixels presented without in_sof while in IDLE -> ignored, no win_valid. in_sof mid-frame (after 7 pixels) -> restart; the next 12-pixel frame produces exactly 12 correct windows, and no win_eof for the aborted frame.
- reset_n pulsed low mid-FLUSH -> outputs zero asynchronously. After release, block is in IDLE with in_ready=1, and a new frame behaves as in the first scenario.
